// File: rtl/sigma_delta_adc_sequencer.sv
// rtl/sigma_delta_adc_sequencer.sv - time-multiplexes one sigma-delta ADC across NCH mux channels
// Per enabled channel: select mux, hold ADC in reset to settle, drop early samples, average, emit.
module sigma_delta_adc_sequencer #(
    parameter int NCH         = 4,
    parameter int WDTH        = 16,
    parameter int SETTLE_CLKS = 64,
    parameter int DISCARD     = 2,
    parameter int AVG_LOG2    = 2,
    localparam int CHW        = $clog2(NCH)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NCH-1:0]  i_ch_mask,
    input  logic            i_scan_start,
    input  logic            i_cont_en,
    input  logic [WDTH-1:0] i_adc_s_data,
    input  logic            i_adc_valid,
    output logic            o_adc_rst,
    output logic [CHW-1:0]  o_mux_sel,
    output logic [WDTH-1:0] o_out_data,
    output logic [CHW-1:0]  o_out_ch,
    output logic            o_out_valid,
    output logic            o_scan_done,
    output logic            o_busy
);

    localparam int NAVG    = 1 << AVG_LOG2;
    localparam int AW      = WDTH + AVG_LOG2;
    localparam int MAX_A   = (SETTLE_CLKS > DISCARD) ? SETTLE_CLKS : DISCARD;
    localparam int CNT_MAX = (MAX_A > NAVG) ? MAX_A : NAVG;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_DISCARD,
        S_ACCUM,
        S_NEXT
    } state_t;

    state_t                r_state;
    logic [NCH-1:0]        r_mask;
    logic [CHW-1:0]        r_cur_ch;
    logic [CW-1:0]         r_cnt;
    logic signed [AW-1:0]  r_acc;

    logic signed [AW-1:0]  w_sample;
    logic signed [AW-1:0]  w_sum;
    logic [CHW-1:0]        w_low_ch;
    logic [CHW-1:0]        w_nxt_ch;
    logic                  w_nxt_found;

    assign w_sample = AW'($signed(i_adc_s_data));
    assign w_sum    = r_acc + w_sample;
    assign o_busy   = (r_state != S_IDLE);

    // Descending scans so the last hit is the lowest qualifying bit.
    always_comb begin
        w_low_ch    = '0;
        w_nxt_ch    = '0;
        w_nxt_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_ch_mask[i]) begin
                w_low_ch = CHW'(i);
            end
            if (r_mask[i] && (i > int'(r_cur_ch))) begin
                w_nxt_ch    = CHW'(i);
                w_nxt_found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_cur_ch    <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            o_adc_rst   <= 1'b1;
            o_mux_sel   <= '0;
            o_out_data  <= '0;
            o_out_ch    <= '0;
            o_out_valid <= 1'b0;
            o_scan_done <= 1'b0;
        end else begin
            o_out_valid <= 1'b0;
            o_scan_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    o_adc_rst <= 1'b1;
                    if (i_scan_start && (|i_ch_mask)) begin
                        r_mask    <= i_ch_mask;
                        r_cur_ch  <= w_low_ch;
                        o_mux_sel <= w_low_ch;
                        r_cnt     <= '0;
                        r_state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == CW'(SETTLE_CLKS - 1)) begin
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        o_adc_rst <= 1'b0;
                        r_state   <= (DISCARD == 0) ? S_ACCUM : S_DISCARD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DISCARD: begin
                    if (i_adc_valid) begin
                        if (r_cnt == CW'(DISCARD - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_ACCUM;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_ACCUM: begin
                    if (i_adc_valid) begin
                        if (r_cnt == CW'(NAVG - 1)) begin
                            o_out_data  <= WDTH'(w_sum >>> AVG_LOG2);
                            o_out_ch    <= r_cur_ch;
                            o_out_valid <= 1'b1;
                            o_scan_done <= !w_nxt_found;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_state     <= S_NEXT;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_NEXT: begin
                    r_cnt <= '0;
                    if (w_nxt_found) begin
                        r_cur_ch  <= w_nxt_ch;
                        o_mux_sel <= w_nxt_ch;
                        o_adc_rst <= 1'b1;
                        r_state   <= S_SETTLE;
                    end else if (i_cont_en && (|i_ch_mask)) begin
                        r_mask    <= i_ch_mask;
                        r_cur_ch  <= w_low_ch;
                        o_mux_sel <= w_low_ch;
                        o_adc_rst <= 1'b1;
                        r_state   <= S_SETTLE;
                    end else begin
                        o_adc_rst <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    o_adc_rst <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sigma_delta_adc_sequencer.md
Name: sigma_delta_adc_sequencer

Overview:
Time-multiplexes one sigma_delta_adc across NCH analog inputs through an external analog mux. For each enabled channel it drives the mux select, holds the ADC in reset while the integrator settles, and drops the first DISCARD decimator outputs. It then averages 2^AVG_LOG2 signed samples and emits one channel-tagged result. It sits between sigma_delta_adc (adc_s_output/adc_valid, rst) and the downstream sample sink.

Parameters:
NCH, 4, number of mux channels (2..16); CHW = $clog2(NCH) is derived locally
WDTH, 16, ADC signed sample width (must match the sigma_delta_adc WDTH)
SETTLE_CLKS, 64, clocks adc_rst is held after every mux change (>=1)
DISCARD, 2, adc_valid pulses dropped after settle (set to STGS); 0 allowed
AVG_LOG2, 2, log2 of the number of samples averaged per result (0 = no averaging)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ch_mask  in  NCH  channel enable bits, bit i = channel i
scan_start  in  1  one-cycle pulse that starts a scan
cont_en  in  1  1 = restart scans back-to-back
adc_s_data  in  WDTH  signed ADC output
adc_valid  in  1  ADC sample strobe
adc_rst  out  1  reset to sigma_delta_adc
mux_sel  out  CHW  analog mux select
out_data  out  WDTH  averaged signed sample
out_ch  out  CHW  channel of out_data
out_valid  out  1  one-cycle result strobe
scan_done  out  1  one-cycle pulse on the last result of a scan
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: adc_rst=1, mux_sel=0, out_data=0, out_ch=0, out_valid=0, scan_done=0, busy=0, FSM=IDLE.
- Reset asserted mid-scan aborts the scan immediately. The accumulator and counters clear, and no partial result is emitted.
- States:
  - IDLE: adc_rst=1. On scan_start=1 with ch_mask!=0: latch ch_mask into mask_q, set cur_ch to the lowest set bit, set mux_sel=cur_ch, go to SETTLE. If ch_mask==0, scan_start is ignored.
  - SETTLE: adc_rst=1 for exactly SETTLE_CLKS cycles, counted from the first SETTLE cycle. Then go to DISCARD with adc_rst=0. adc_valid is ignored here.
  - DISCARD: count adc_valid pulses. After DISCARD of them go to ACCUM. If DISCARD=0, go to ACCUM directly, with no dead cycle.
  - ACCUM: sign-extend adc_s_data into a WDTH+AVG_LOG2 accumulator on each adc_valid. On the 2^AVG_LOG2-th pulse, register out_data = (acc + sample) >>> AVG_LOG2 (arithmetic shift, truncates toward -inf), out_ch=cur_ch, out_valid=1 on the next cycle. Then go to NEXT.
  - NEXT (one cycle): find the next higher set bit of mask_q.
    - If one exists: cur_ch = that bit, go to SETTLE.
    - Else, on scan end with cont_en=1: reload mask_q from the live ch_mask and go to SETTLE with the lowest set bit. If the live ch_mask is 0, go to IDLE instead.
    - Else, on scan end with cont_en=0: go to IDLE.
- scan_done is asserted in the same cycle as out_valid for the last channel of the scan.
- mux_sel changes only on entry to SETTLE and is stable outside SETTLE.
- A single enabled channel in continuous mode still passes through SETTLE and DISCARD for every result.
- Mask and start timing:
  - ch_mask changes during a scan take effect only at the next scan start or continuous reload.
  - scan_start while busy=1 is ignored.
  - cont_en falling mid-scan lets the current scan complete, then the FSM goes to IDLE.
- Latency per channel: SETTLE_CLKS + 1 + (DISCARD + 2^AVG_LOG2) adc_valid periods + 1 clock.

Test Plan:
- Sequence order: ch_mask=4'b1011, scan_start pulse, cont_en=0, ADC model returns 100*(ch+1) -> out_ch sequence 0,1,3 with out_data 100,200,400. scan_done only with ch 3. busy returns to 0 and adc_rst=1.
- Averaging and sign: AVG_LOG2=2, samples -3,-4,-4,-4 on one channel -> out_data = -4 (-15>>>2). The 2 discarded samples preceding them (value 1000) do not affect the result.
- Settle and discard timing: count cycles with adc_rst=1 after each mux_sel change -> exactly 64. The first 2 adc_valid after adc_rst falls are never accumulated. adc_valid pulses forced during SETTLE are ignored.
- Boundaries:
  - ch_mask=0 with a scan_start pulse -> busy stays 0.
  - scan_start pulsed mid-scan -> ignored, with no extra results.
  - ch_mask=4'b1000 with cont_en=1 -> repeated out_ch=3 results, each preceded by a 64-cycle adc_rst.
- Continuous reload: cont_en=1, mask 4'b0011, mask changed to 4'b0100 mid-scan -> channels 0,1 then 2,2,... Dropping cont_en during a ch 2 conversion -> that result is emitted with scan_done, then the FSM goes to IDLE.
- Async reset mid-ACCUM: rst pulse asserted between clock edges -> outputs take their reset values immediately with no clock. After release, a new scan's first result matches a fresh-start golden value.
